switch_reader: RTL and testbench
================================

# switch_reader

Memory-mapped input peripheral that samples the 24 board switches, debounces each bit, and returns their state to the CPU over the 16-bit I/O read bus. It mirrors the LED output port: the same chip-select plus low-address decode scheme, read direction instead of write. A sticky change flag tells software that any debounced switch has toggled since the last status read.

## Interface
- SAMPLE_DIV, 50000: led_clk cycles per debounce sample tick (≥2)
- STABLE_CNT, 4: consecutive mismatching ticks required to accept a new switch level (≥1)
- led_clk  in  1  system clock; all state on rising edge
- ledrst  in  1  reset, asynchronous, active-high (reset ledrst, asynchronous, active-high; clock led_clk)
- swcs  in  1  switch-port chip select from the memory/IO decoder
- swread  in  1  read strobe
- swaddr  in  2  low address bits
- switch_in  in  24  raw, asynchronous board switch levels
- swrdata  out  16  registered read data
- swchg  out  1  sticky "debounced state changed" flag

## Operation
- Synchronizer: 2-flop chain per bit on switch_in, giving sync[23:0].
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 for the one cycle where count==SAMPLE_DIV-1.
- Per-bit debounce, on tick only:
  - sync==deb: counter cleared.
  - sync!=deb: counter increments. When the increment reaches STABLE_CNT, deb<=sync and counter clears.
  - Counter width is clog2(STABLE_CNT+1). It never exceeds STABLE_CNT.
- Change flag: swchg is set in any cycle where any deb bit flips. It is cleared by a status read (swcs&&swread&&swaddr==2'b01). If a set and a clear occur in the same cycle, the set wins.
- Read decode, registered, on swcs&&swread:
  - 2'b00 → deb[15:0]
  - 2'b10 → {8'h00, deb[23:16]}
  - 2'b01 → {15'b0, swchg} (value before any same-cycle clear)
  - 2'b11 → 16'h0000
- When not (swcs&&swread), swrdata<=16'h0000 so the read bus can be OR-combined.
- Writes are ignored; the port has no write strobe.

## Timing
- Reset values (all outputs and internal state): swrdata=0, swchg=0, deb=0, synchronizers=0, tick counter=0, per-bit counters=0. Reset takes effect immediately, asynchronously.
- Read latency: 1 cycle. Data is valid on the edge after the cycle in which swcs&&swread is sampled high. Back-to-back reads are allowed every cycle.
- Input-to-deb latency after a clean edge: 2 cycles of synchronization, then STABLE_CNT ticks. Worst case is 2+STABLE_CNT·SAMPLE_DIV cycles; best case is 2+(STABLE_CNT-1)·SAMPLE_DIV+1.
- A glitch shorter than STABLE_CNT consecutive ticks never reaches deb.
- swchg rises in the same cycle deb updates. It is visible through a status read issued on the following cycle.
- Reset asserted mid-debounce discards partial counts. After release, deb reacquires the current switches from zero, with the full latency.
- Tick-counter wrap is free-running and independent of reads.

## Structure
- Shared package `io_pkg`:
  - address constants SW_ADDR_LO=2'b00, SW_ADDR_STAT=2'b01, SW_ADDR_HI=2'b10
  - SW_WIDTH=24
  - IO_DATA_W=16
  - the same constants are reused by the LED port decode
- Sub-module `switch_debounce_bit`: synchronizer, counter and deb register for one bit. Inputs are the tick and raw bit; outputs are deb and a changed pulse. It is generate-instantiated SW_WIDTH times.
- The top level holds the tick counter, change flag and read mux.

## Test plan
(Sim parameters: SAMPLE_DIV=4, STABLE_CNT=3.)
- Reset: pulse ledrst mid-clock → swrdata=16'h0000 and swchg=0 immediately. Reads of 00/10 then return 0.
- Steady input: switch_in=24'hA51234, wait 16 cycles. Read 00 → swrdata=16'h1234 one cycle later; read 10 → 16'h00A5; swchg=1.
- Glitch rejection: from deb=0, set bit0=1 for 2 ticks, then 0 → read 00 returns 16'h0000 and swchg stays 0. Holding it for 3 ticks → 16'h0001.
- Status read: read 01 → 16'h0001, then swchg=0. Repeat with a deb flip in the same cycle as the status read → swchg stays 1.
- Decode gating: swread=1 with swcs=0, or swaddr=2'b11 → swrdata=16'h0000.
- Reset mid-debounce: assert ledrst after 2 mismatching ticks, then release → deb=0. The new level appears only after 3 further ticks.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared I/O port address map and widths for the LED and switch ports
package io_pkg;

    localparam logic [1:0] SW_ADDR_LO   = 2'b00;
    localparam logic [1:0] SW_ADDR_STAT = 2'b01;
    localparam logic [1:0] SW_ADDR_HI   = 2'b10;
    localparam logic [1:0] SW_ADDR_RSVD = 2'b11;

    localparam int SW_WIDTH  = 24;
    localparam int IO_DATA_W = 16;

endpackage

// File: rtl/switch_debounce_bit.sv
// rtl/switch_debounce_bit.sv - two-flop synchronizer plus tick-sampled debounce for one switch
module switch_debounce_bit #(
    parameter int STABLE_CNT = 4
) (
    input  logic led_clk,
    input  logic ledrst,
    input  logic tick,
    input  logic raw_in,
    output logic deb,
    output logic changed
);

    localparam int             CW      = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q,   deb_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Next-state: synchronize the raw level, then count consecutive mismatching ticks
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q + CW'(1) == CNT_MAX) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State register; reset discards any partial count
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb     = deb_q;
    // Asserted in the cycle whose edge flips deb, so the flag sets on that same edge
    assign changed = deb_d ^ deb_q;

endmodule

// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - debounced 24-bit switch input port on the 16-bit I/O read bus
module switch_reader
    import io_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic                 led_clk,
    input  logic                 ledrst,
    input  logic                 swcs,
    input  logic                 swread,
    input  logic [1:0]           swaddr,
    input  logic [SW_WIDTH-1:0]  switch_in,
    output logic [IO_DATA_W-1:0] swrdata,
    output logic                 swchg
);

    localparam int            TW        = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic                   tick;
    logic [SW_WIDTH-1:0]    deb_vec;
    logic [SW_WIDTH-1:0]    chg_vec;
    logic                   any_chg;
    logic                   rd_en;
    logic                   stat_rd;
    logic                   swchg_q, swchg_d;
    logic [IO_DATA_W-1:0]   swrdata_q, swrdata_d;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign any_chg = |chg_vec;
    assign rd_en   = swcs && swread;
    assign stat_rd = rd_en && (swaddr == SW_ADDR_STAT);

    // Free-running sample divider, independent of bus activity
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_bit (
            .led_clk (led_clk),
            .ledrst  (ledrst),
            .tick    (tick),
            .raw_in  (switch_in[i]),
            .deb     (deb_vec[i]),
            .changed (chg_vec[i])
        );
    end

    // Sticky change flag: a new flip outranks a same-cycle status-read clear
    always_comb begin
        swchg_d = swchg_q;
        if (any_chg) begin
            swchg_d = 1'b1;
        end else if (stat_rd) begin
            swchg_d = 1'b0;
        end
    end

    // Read mux; idle cycles drive zero so the bus can be OR-combined with other ports
    always_comb begin
        swrdata_d = '0;
        if (rd_en) begin
            case (swaddr)
                SW_ADDR_LO:   swrdata_d = deb_vec[15:0];
                SW_ADDR_HI:   swrdata_d = {8'h00, deb_vec[SW_WIDTH-1:16]};
                SW_ADDR_STAT: swrdata_d = {15'b0, swchg_q};
                default:      swrdata_d = '0;
            endcase
        end
    end

    // Top-level state registers
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            tick_cnt_q <= '0;
            swchg_q    <= 1'b0;
            swrdata_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            swchg_q    <= swchg_d;
            swrdata_q  <= swrdata_d;
        end
    end

    assign swrdata = swrdata_q;
    assign swchg   = swchg_q;

endmodule

// File: tb/tb_switch_reader.sv
// tb/tb_switch_reader.sv - randomized and directed bench for switch_reader against a behavioural model
module tb_switch_reader;
    import io_pkg::*;

    localparam int DIV = 4;
    localparam int STB = 3;

    logic        led_clk   = 1'b0;
    logic        ledrst    = 1'b0;
    logic        swcs      = 1'b0;
    logic        swread    = 1'b0;
    logic [1:0]  swaddr    = 2'b00;
    logic [23:0] switch_in = 24'h0;
    logic [15:0] swrdata;
    logic        swchg;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_s1, m_s2, m_deb;
    int          m_tick;
    int          m_mis [24];
    logic        m_chg;
    logic [15:0] m_rd;

    switch_reader #(
        .SAMPLE_DIV (DIV),
        .STABLE_CNT (STB)
    ) dut (
        .led_clk   (led_clk),
        .ledrst    (ledrst),
        .swcs      (swcs),
        .swread    (swread),
        .swaddr    (swaddr),
        .switch_in (switch_in),
        .swrdata   (swrdata),
        .swchg     (swchg)
    );

    always #5 led_clk = ~led_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_deb  = '0;
        m_tick = 0;
        m_chg  = 1'b0;
        m_rd   = '0;
        for (int i = 0; i < 24; i++) m_mis[i] = 0;
    endtask

    // A switch adopts its synchronized level once it has disagreed with the
    // accepted level on STB consecutive sample ticks.
    task automatic model_edge();
        logic [23:0] nd;
        bit          is_tick;
        if (ledrst) begin
            model_reset();
            return;
        end
        nd      = m_deb;
        is_tick = (m_tick == DIV - 1);
        if (is_tick) begin
            for (int b = 0; b < 24; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_mis[b] = m_mis[b] + 1;
                    if (m_mis[b] == STB) begin
                        nd[b]    = m_s2[b];
                        m_mis[b] = 0;
                    end
                end else begin
                    m_mis[b] = 0;
                end
            end
        end
        if (swcs && swread) begin
            case (swaddr)
                2'b00:   m_rd = m_deb[15:0];
                2'b10:   m_rd = {8'h00, m_deb[23:16]};
                2'b01:   m_rd = {15'b0, m_chg};
                default: m_rd = 16'h0000;
            endcase
        end else begin
            m_rd = 16'h0000;
        end
        if (nd != m_deb)
            m_chg = 1'b1;
        else if (swcs && swread && swaddr == 2'b01)
            m_chg = 1'b0;
        m_deb  = nd;
        m_s2   = m_s1;
        m_s1   = switch_in;
        m_tick = (m_tick + 1) % DIV;
    endtask

    task automatic cycle();
        @(posedge led_clk);
        model_edge();
        @(negedge led_clk);
        check_eq("swrdata", 32'(swrdata), 32'(m_rd));
        check_eq("swchg", 32'(swchg), 32'(m_chg));
    endtask

    task automatic read_port(input logic [1:0] addr);
        swcs   = 1'b1;
        swread = 1'b1;
        swaddr = addr;
        cycle();
        swcs   = 1'b0;
        swread = 1'b0;
        swaddr = 2'b00;
    endtask

    task automatic do_reset();
        #2;
        ledrst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_swrdata", 32'(swrdata), 32'h0);
        check_eq("rst_swchg", 32'(swchg), 32'h0);
        cycle();
        #2;
        ledrst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ones;

        model_reset();
        do_reset();
        read_port(SW_ADDR_LO);
        check_eq("rst_read_lo", 32'(swrdata), 32'h0);
        read_port(SW_ADDR_HI);
        check_eq("rst_read_hi", 32'(swrdata), 32'h0);

        switch_in = 24'hA51234;
        repeat (16) cycle();
        read_port(SW_ADDR_LO);
        check_eq("steady_lo", 32'(swrdata), 32'h1234);
        read_port(SW_ADDR_HI);
        check_eq("steady_hi", 32'(swrdata), 32'h00A5);
        check_eq("steady_chg", 32'(swchg), 32'h1);

        read_port(SW_ADDR_STAT);
        check_eq("stat_read", 32'(swrdata), 32'h1);
        check_eq("stat_clear", 32'(swchg), 32'h0);

        switch_in = 24'h0;
        repeat (20) cycle();
        read_port(SW_ADDR_STAT);
        switch_in = 24'h000001;
        repeat (8) cycle();
        switch_in = 24'h0;
        repeat (20) cycle();
        read_port(SW_ADDR_LO);
        check_eq("glitch_lo", 32'(swrdata), 32'h0);
        check_eq("glitch_chg", 32'(swchg), 32'h0);
        switch_in = 24'h000001;
        repeat (20) cycle();
        read_port(SW_ADDR_LO);
        check_eq("hold_lo", 32'(swrdata), 32'h0001);

        read_port(SW_ADDR_STAT);
        switch_in = 24'h0;
        ones = 0;
        swcs   = 1'b1;
        swread = 1'b1;
        swaddr = SW_ADDR_STAT;
        repeat (24) begin
            cycle();
            if (swrdata == 16'h0001) ones++;
        end
        swcs   = 1'b0;
        swread = 1'b0;
        swaddr = 2'b00;
        check_eq("setwins_count", 32'(ones), 32'd1);
        check_eq("setwins_final", 32'(swchg), 32'h0);

        switch_in = 24'hFFFFFF;
        repeat (20) cycle();
        swread = 1'b1;
        swcs   = 1'b0;
        swaddr = SW_ADDR_LO;
        cycle();
        check_eq("gate_nocs", 32'(swrdata), 32'h0);
        swcs   = 1'b1;
        swaddr = SW_ADDR_RSVD;
        cycle();
        check_eq("gate_rsvd", 32'(swrdata), 32'h0);
        swcs   = 1'b0;
        swread = 1'b0;
        swaddr = 2'b00;

        switch_in = 24'h0;
        do_reset();
        repeat (8) cycle();
        switch_in = 24'h00005A;
        n = 0;
        while (m_mis[1] < 2 && n < 40) begin
            cycle();
            n++;
        end
        check_eq("middeb_reach", 32'(n < 40), 32'h1);
        do_reset();
        read_port(SW_ADDR_LO);
        check_eq("middeb_cleared", 32'(swrdata), 32'h0);
        swcs   = 1'b1;
        swread = 1'b1;
        swaddr = SW_ADDR_LO;
        n = 1;
        while (swrdata != 16'h005A && n < 40) begin
            cycle();
            n++;
        end
        swcs   = 1'b0;
        swread = 1'b0;
        check_eq("middeb_lat_lo", 32'(n >= 12), 32'h1);
        check_eq("middeb_lat_hi", 32'(n <= 15), 32'h1);

        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 15) == 0)
                switch_in = 24'($urandom);
            else if ($urandom_range(0, 7) == 0)
                switch_in[$urandom_range(0, 23)] ^= 1'b1;
            swcs   = ($urandom_range(0, 3) != 0);
            swread = 1'($urandom_range(0, 1));
            swaddr = 2'($urandom);
            if ($urandom_range(0, 599) == 0)
                do_reset();
            else
                cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
